data_memory_bank: RTL and testbench

DATA_MEMORY_BANK -- requirements
Module: data_memory_bank

---
 rtl/data_memory_bank.sv | 132 +++++++++++++
 tb/tb_data_memory_bank.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bank.sv
// 16x16 register-file data bank with a sequenced clear.
// Optional accepted-write counter enabled by DMEM_WRCOUNT_EN.
`timescale 1ns/1ps
module data_memory_bank #(
  parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        WriteEnable,
  input  logic [3:0]  WriteAddress,
  input  logic [15:0] WriteData,
  input  logic        ClearReq,
  output logic        Busy,
  output logic [15:0] memword0,
  output logic [15:0] memword1,
  output logic [15:0] memword2,
  output logic [15:0] memword3,
  output logic [15:0] memword4,
  output logic [15:0] memword5,
  output logic [15:0] memword6,
  output logic [15:0] memword7,
  output logic [15:0] memword8,
  output logic [15:0] memword9,
  output logic [15:0] memword10,
  output logic [15:0] memword11,
  output logic [15:0] memword12,
  output logic [15:0] memword13,
  output logic [15:0] memword14,
  output logic [15:0] memword15
`ifdef DMEM_WRCOUNT_EN
  ,
  output logic [15:0] WriteCount
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  idx;
  logic [15:0] mem [16];

  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        accept;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Clear has priority over a coincident write; CLEAR owns the write port.
  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    wr_addr = WriteAddress;
    wr_data = WriteData;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ClearReq) begin
          state_n = CLEAR;
        end else if (WriteEnable) begin
          wr_en  = 1'b1;
          accept = 1'b1;
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = idx;
        wr_data = CLEAR_VALUE;
        if (idx == 4'd15) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      idx <= 4'd0;
    end else if (state == CLEAR) begin
      idx <= idx + 4'd1;
    end else begin
      idx <= 4'd0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign Busy = (state == CLEAR);

`ifdef DMEM_WRCOUNT_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      WriteCount <= 16'h0000;
    end else if (accept && WriteCount != 16'hFFFF) begin
      WriteCount <= WriteCount + 16'd1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  assign memword0  = mem[0];
  assign memword1  = mem[1];
  assign memword2  = mem[2];
  assign memword3  = mem[3];
  assign memword4  = mem[4];
  assign memword5  = mem[5];
  assign memword6  = mem[6];
  assign memword7  = mem[7];
  assign memword8  = mem[8];
  assign memword9  = mem[9];
  assign memword10 = mem[10];
  assign memword11 = mem[11];
  assign memword12 = mem[12];
  assign memword13 = mem[13];
  assign memword14 = mem[14];
  assign memword15 = mem[15];

endmodule

// File: tb/tb_data_memory_bank.sv
// Bench for data_memory_bank: vector table, directed clear/reset
// sequences and a randomized run against an array-based model.
`timescale 1ns/1ps
module tb_data_memory_bank;

  localparam logic [15:0] CV = 16'h00FF;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b1;
  logic        WriteEnable = 1'b0;
  logic [3:0]  WriteAddress = 4'd0;
  logic [15:0] WriteData = 16'h0000;
  logic        ClearReq = 1'b0;
  logic        Busy;
  logic [15:0] mw [16];
`ifdef DMEM_WRCOUNT_EN
  logic [15:0] WriteCount;
`endif

  data_memory_bank #(.CLEAR_VALUE(CV)) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .WriteEnable(WriteEnable),
    .WriteAddress(WriteAddress),
    .WriteData(WriteData),
    .ClearReq(ClearReq),
    .Busy(Busy),
    .memword0(mw[0]),
    .memword1(mw[1]),
    .memword2(mw[2]),
    .memword3(mw[3]),
    .memword4(mw[4]),
    .memword5(mw[5]),
    .memword6(mw[6]),
    .memword7(mw[7]),
    .memword8(mw[8]),
    .memword9(mw[9]),
    .memword10(mw[10]),
    .memword11(mw[11]),
    .memword12(mw[12]),
    .memword13(mw[13]),
    .memword14(mw[14]),
    .memword15(mw[15])
`ifdef DMEM_WRCOUNT_EN
    ,
    .WriteCount(WriteCount)
`endif
  );

  always #5 Clock = ~Clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: word array, remaining clear cycles, clear position
  logic [15:0] m [16];
  int left;
  int pos;
  int cnt;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        clr;
    logic [3:0]  caddr;
    logic [15:0] cdata;
    logic        cbusy;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = 16'h0000;
    left = 0;
    pos = 0;
    cnt = 0;
  endtask

  task automatic model_edge(input logic we, input logic [3:0] addr,
                            input logic [15:0] data, input logic clr);
    if (left > 0) begin
      m[pos] = CV;
      pos++;
      left--;
    end else if (clr) begin
      left = 16;
      pos = 0;
    end else if (we) begin
      m[addr] = data;
      if (cnt < 65535) cnt++;
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s word%0d", tag, i), mw[i], m[i]);
    chk({tag, " busy"}, 16'(Busy), 16'(left > 0));
`ifdef DMEM_WRCOUNT_EN
    chk({tag, " wrcount"}, WriteCount, 16'(cnt));
`endif
  endtask

  task automatic step(input logic we, input logic [3:0] addr,
                      input logic [15:0] data, input logic clr,
                      input bit check = 1'b1);
    WriteEnable = we;
    WriteAddress = addr;
    WriteData = data;
    ClearReq = clr;
    @(posedge Clock);
    model_edge(we, addr, data, clr);
    #1;
    if (check) check_model("step");
    WriteEnable = 1'b0;
    ClearReq = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #2;
    model_reset();
    check_model("reset");
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic wait_clear(inout int n);
    while (Busy === 1'b1 && n < 40) begin
      n++;
      step(1'b0, 4'd0, 16'h0000, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int saved;
    tbl[0] = '{1'b1, 4'd3,  16'hA5A5, 1'b0, 4'd3,  16'hA5A5, 1'b0};
    tbl[1] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd2,  16'h0000, 1'b0};
    tbl[2] = '{1'b1, 4'd3,  16'h1111, 1'b0, 4'd3,  16'h1111, 1'b0};
    tbl[3] = '{1'b1, 4'd3,  16'h2222, 1'b0, 4'd3,  16'h2222, 1'b0};
    tbl[4] = '{1'b1, 4'd15, 16'hFFFF, 1'b0, 4'd15, 16'hFFFF, 1'b0};
    tbl[5] = '{1'b1, 4'd0,  16'h0001, 1'b0, 4'd0,  16'h0001, 1'b0};
    tbl[6] = '{1'b0, 4'd9,  16'h7777, 1'b0, 4'd3,  16'h2222, 1'b0};
    tbl[7] = '{1'b1, 4'd4,  16'hBEEF, 1'b0, 4'd4,  16'hBEEF, 1'b0};

    #1;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].clr);
      chk($sformatf("tbl%0d word", i), mw[tbl[i].caddr], tbl[i].cdata);
      chk($sformatf("tbl%0d busy", i), 16'(Busy), 16'(tbl[i].cbusy));
    end

    do_reset();
    for (int k = 0; k < 16; k++)
      step(1'b1, 4'(k), 16'h1000 + 16'(k), 1'b0);
    for (int k = 0; k < 16; k++)
      chk($sformatf("fill word%0d", k), mw[k], 16'h1000 + 16'(k));
`ifdef DMEM_WRCOUNT_EN
    chk("fill wrcount", WriteCount, 16'd16);
`endif

    step(1'b0, 4'd0, 16'h0000, 1'b1);
    n = 0;
    wait_clear(n);
    chk("clear busy cycles", 16'(n), 16'd16);
    for (int k = 0; k < 16; k++)
      chk($sformatf("cleared word%0d", k), mw[k], CV);

    step(1'b1, 4'd5, 16'h5555, 1'b0);
    saved = cnt;
    step(1'b0, 4'd0, 16'h0000, 1'b1);
    step(1'b1, 4'd5, 16'hBEEF, 1'b0);
    step(1'b0, 4'd0, 16'h0000, 1'b1);
    n = 2;
    wait_clear(n);
    chk("busy ignore cycles", 16'(n), 16'd16);
    chk("busy ignore word5", mw[5], CV);
`ifdef DMEM_WRCOUNT_EN
    chk("busy ignore wrcount", WriteCount, 16'(saved));
`endif

    step(1'b1, 4'd2, 16'h1234, 1'b1);
    chk("clr wins busy", 16'(Busy), 16'd1);
    for (int k = 0; k < 8; k++) step(1'b0, 4'd0, 16'h0000, 1'b0);
    chk("clr wins word2", mw[2], CV);
    chk("mid clear busy", 16'(Busy), 16'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    for (int k = 0; k < 16; k++)
      chk($sformatf("abort word%0d", k), mw[k], 16'h0000);
    chk("abort busy", 16'(Busy), 16'd0);
    model_reset();
    @(negedge Clock);
    Reset_n = 1'b1;
    step(1'b0, 4'd0, 16'h0000, 1'b0);
    chk("post abort idle", 16'(Busy), 16'd0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           16'($urandom), $urandom_range(0, 40) == 0);
    n = 0;
    wait_clear(n);

`ifdef DMEM_WRCOUNT_EN
    do_reset();
    for (int i = 0; i < 65534; i++)
      step(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 1'b0, 1'b0);
    check_model("sat pre");
    chk("sat pre wrcount", WriteCount, 16'hFFFE);
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i), 16'h4000, 1'b0);
    chk("sat wrcount", WriteCount, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
